// File: rtl/fft_block_unpacker.sv
// Captures one N-sample frame delivered as N/NUM wide blocks, then drains it one complex
// sample per cycle on a valid/ready stream. Define FFT_UNPACK_BITREV_EN for bit-reversed read addressing.
module fft_block_unpacker #(
   parameter int IN_WIDTH = 10,
   parameter int NUM      = 16,
   parameter int N        = 512
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_in,
   input  logic [IN_WIDTH*NUM-1:0]    din_i,
   input  logic [IN_WIDTH*NUM-1:0]    din_q,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic signed [IN_WIDTH-1:0] dout_i,
   output logic signed [IN_WIDTH-1:0] dout_q,
   output logic [$clog2(N)-1:0]       dout_index,
   output logic                       dout_last,
   output logic                       busy,
   output logic                       short_frame,
   output logic                       overflow
);
   localparam int ABITS = $clog2(N);
   localparam int LBITS = $clog2(NUM);
   localparam int BBITS = ABITS - LBITS;
   localparam logic [BBITS-1:0] LAST_BLK = BBITS'(N / NUM - 1);
   localparam logic [ABITS-1:0] LAST_RD  = ABITS'(N - 1);

   typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

   state_t                     state_q;
   logic [BBITS-1:0]           blk_cnt_q;
   logic [ABITS-1:0]           rd_cnt_q;
   logic                       dout_valid_q;
   logic                       busy_q;
   logic                       short_q;
   logic                       ovf_q;
   logic [BBITS-1:0]           wr_blk;
   logic                       wr_en;
   logic [ABITS-1:0]           rd_addr;
   logic signed [IN_WIDTH-1:0] mem_i_q [N];
   logic signed [IN_WIDTH-1:0] mem_q_q [N];

   function automatic logic [ABITS-1:0] bitrev(input logic [ABITS-1:0] a);
      logic [ABITS-1:0] r;
      for (int b = 0; b < ABITS; b++) r[b] = a[ABITS-1-b];
      return r;
   endfunction

   // Block 0 is written straight from IDLE, so the write address ignores the stale count there.
   assign wr_blk = (state_q == IDLE) ? '0 : blk_cnt_q;
   assign wr_en  = valid_in && (state_q != DRAIN);

`ifdef FFT_UNPACK_BITREV_EN
   assign rd_addr = bitrev(rd_cnt_q);
`else
   assign rd_addr = rd_cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int j = 0; j < NUM; j++) begin
            mem_i_q[{wr_blk, LBITS'(j)}] <= din_i[j*IN_WIDTH +: IN_WIDTH];
            mem_q_q[{wr_blk, LBITS'(j)}] <= din_q[j*IN_WIDTH +: IN_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         blk_cnt_q    <= '0;
         rd_cnt_q     <= '0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         short_q      <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         short_q <= 1'b0;
         unique case (state_q)
            IDLE, FILL: begin
               if (valid_in) begin
                  busy_q <= 1'b1;
                  if (wr_blk == LAST_BLK) begin
                     state_q      <= DRAIN;
                     dout_valid_q <= 1'b1;
                     rd_cnt_q     <= '0;
                  end else begin
                     state_q   <= FILL;
                     blk_cnt_q <= wr_blk + 1'b1;
                  end
               end else if (state_q == FILL) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  short_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (valid_in) ovf_q <= 1'b1;
               if (dout_ready) begin
                  if (rd_cnt_q == LAST_RD) begin
                     state_q      <= IDLE;
                     dout_valid_q <= 1'b0;
                     busy_q       <= 1'b0;
                     rd_cnt_q     <= '0;
                  end else begin
                     rd_cnt_q <= rd_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q      <= IDLE;
               dout_valid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign dout_valid  = dout_valid_q;
   assign dout_i      = dout_valid_q ? mem_i_q[rd_addr] : '0;
   assign dout_q      = dout_valid_q ? mem_q_q[rd_addr] : '0;
   assign dout_index  = rd_cnt_q;
   assign dout_last   = dout_valid_q && (rd_cnt_q == LAST_RD);
   assign busy        = busy_q;
   assign short_frame = short_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_fft_block_unpacker.sv
// Self-checking bench for fft_block_unpacker: table-driven ramp frames plus randomized frames
// compared against a frame-array reference model.
module tb_fft_block_unpacker;
   localparam int W   = 10;
   localparam int NUM = 16;
   localparam int N   = 512;
   localparam int NB  = N / NUM;
   localparam int AB  = $clog2(N);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                valid_in = 1'b0;
   logic                dout_ready = 1'b0;
   logic [W*NUM-1:0]    din_i = '0;
   logic [W*NUM-1:0]    din_q = '0;
   logic                dout_valid, dout_last, busy, short_frame, overflow;
   logic signed [W-1:0] dout_i, dout_q;
   logic [AB-1:0]       dout_index;

   int n_chk = 0;
   int n_fail = 0;
   int fi [N];
   int fq [N];
   int got_i [N];
   int got_q [N];

   typedef struct {
      int mode;
      int exp_cycles;
      int i0;
      int q0;
      int il;
      int ql;
   } row_t;
   row_t tbl [3];

   fft_block_unpacker #(.IN_WIDTH(W), .NUM(NUM), .N(N)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .din_i(din_i), .din_q(din_q),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_i(dout_i), .dout_q(dout_q),
      .dout_index(dout_index), .dout_last(dout_last), .busy(busy),
      .short_frame(short_frame), .overflow(overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference read order: sample n of the stream comes from frame address k.
   function automatic int exp_addr(input int n);
`ifdef FFT_UNPACK_BITREV_EN
      int r = 0;
      for (int b = 0; b < AB; b++)
         if (((n >> b) & 1) != 0) r = r | (1 << (AB - 1 - b));
      return r;
`else
      return n;
`endif
   endfunction

   task automatic fill_ramp();
      for (int k = 0; k < N; k++) begin
         fi[k] = k - 256;
         fq[k] = 255 - k;
      end
   endtask

   task automatic fill_rand();
      for (int k = 0; k < N; k++) begin
         fi[k] = int'($urandom_range(0, 1023)) - 512;
         fq[k] = int'($urandom_range(0, 1023)) - 512;
      end
   endtask

   task automatic rand_din();
      for (int j = 0; j < NUM; j++) begin
         din_i[j*W +: W] = W'($urandom_range(0, 1023));
         din_q[j*W +: W] = W'($urandom_range(0, 1023));
      end
   endtask

   task automatic send_blocks(input int nblk);
      int t;
      for (int b = 0; b < nblk; b++) begin
         for (int j = 0; j < NUM; j++) begin
            t = fi[b*NUM + j];
            din_i[j*W +: W] = t[W-1:0];
            t = fq[b*NUM + j];
            din_q[j*W +: W] = t[W-1:0];
         end
         valid_in = 1'b1;
         if (b == NB - 1) chk("dout_valid before last block", int'(dout_valid), 0);
         tick();
      end
      valid_in = 1'b0;
   endtask

   task automatic send_frame();
      send_blocks(NB);
      chk("dout_valid one cycle after last block", int'(dout_valid), 1);
      chk("first dout_index", int'(dout_index), 0);
      chk("busy during drain", int'(busy), 1);
   endtask

   // mode: 0 ready high, 1 toggle 1/0, 2 every third cycle, 3 random.
   task automatic drain(input int mode, input int ovf_at, input int stop_at,
                        output int cycles, output int nd, output int errs);
      int n, ovf_cnt;
      logic rdy, held;
      int sv_i, sv_q, sv_idx, sv_last, k;
      n = 0; cycles = 0; errs = 0; ovf_cnt = 0; held = 1'b0;
      sv_i = 0; sv_q = 0; sv_idx = 0; sv_last = 0;
      while (n < N && cycles < 4000 && !(stop_at >= 0 && n == stop_at)) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cycles % 2) == 0;
            2:       rdy = (cycles % 3) == 0;
            default: rdy = $urandom_range(0, 3) != 0;
         endcase
         if (ovf_at >= 0 && n >= ovf_at && ovf_cnt < 3) begin
            valid_in = 1'b1;
            rand_din();
            ovf_cnt++;
         end else begin
            valid_in = 1'b0;
         end
         dout_ready = rdy;
         if (!dout_valid) errs++;
         if (int'(dout_index) != n) errs++;
         if (int'(dout_last) != ((n == N - 1) ? 1 : 0)) errs++;
         if (held && (int'(dout_i) != sv_i || int'(dout_q) != sv_q ||
                      int'(dout_index) != sv_idx || int'(dout_last) != sv_last)) errs++;
         if (dout_valid && rdy) begin
            k = exp_addr(n);
            if (int'(dout_i) != fi[k] || int'(dout_q) != fq[k]) errs++;
            got_i[n] = int'(dout_i);
            got_q[n] = int'(dout_q);
            n++;
         end
         held = dout_valid && !rdy;
         sv_i = int'(dout_i); sv_q = int'(dout_q);
         sv_idx = int'(dout_index); sv_last = int'(dout_last);
         tick();
         cycles++;
      end
      valid_in = 1'b0;
      dout_ready = 1'b0;
      nd = n;
   endtask

   initial begin
      int cyc, nd, errs;
      tbl[0] = '{mode: 0, exp_cycles: 512,  i0: -256, q0: 255, il: 255, ql: -256};
      tbl[1] = '{mode: 1, exp_cycles: 1023, i0: -256, q0: 255, il: 255, ql: -256};
      tbl[2] = '{mode: 2, exp_cycles: 1534, i0: -256, q0: 255, il: 255, ql: -256};

      repeat (3) @(posedge clk);
      #1;
      chk("reset dout_valid", int'(dout_valid), 0);
      chk("reset dout_i", int'(dout_i), 0);
      chk("reset dout_q", int'(dout_q), 0);
      chk("reset dout_index", int'(dout_index), 0);
      chk("reset dout_last", int'(dout_last), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset short_frame", int'(short_frame), 0);
      chk("reset overflow", int'(overflow), 0);
      rst = 1'b0;
      tick();

      for (int r = 0; r < 3; r++) begin
         fill_ramp();
         send_frame();
         drain(tbl[r].mode, -1, -1, cyc, nd, errs);
         chk($sformatf("row%0d samples drained", r), nd, N);
         chk($sformatf("row%0d stream errors", r), errs, 0);
         chk($sformatf("row%0d drain cycles", r), cyc, tbl[r].exp_cycles);
         chk($sformatf("row%0d I n=0", r), got_i[0], tbl[r].i0);
         chk($sformatf("row%0d Q n=0", r), got_q[0], tbl[r].q0);
         chk($sformatf("row%0d I n=511", r), got_i[N-1], tbl[r].il);
         chk($sformatf("row%0d Q n=511", r), got_q[N-1], tbl[r].ql);
         chk($sformatf("row%0d dout_valid after last", r), int'(dout_valid), 0);
         chk($sformatf("row%0d busy after last", r), int'(busy), 0);
         if (r == 0) begin
            chk("frame period first block to last transfer", NB + cyc, 544);
`ifdef FFT_UNPACK_BITREV_EN
            chk("bitrev I n=1", got_i[1], 0);
            chk("bitrev I n=2", got_i[2], -128);
`else
            chk("linear I n=1", got_i[1], -255);
            chk("linear I n=2", got_i[2], -254);
`endif
         end
      end
      chk("overflow clear after clean frames", int'(overflow), 0);

      fill_rand();
      send_blocks(10);
      tick();
      chk("short_frame pulse", int'(short_frame), 1);
      chk("busy after short burst", int'(busy), 0);
      chk("dout_valid after short burst", int'(dout_valid), 0);
      tick();
      chk("short_frame single cycle", int'(short_frame), 0);
      fill_ramp();
      send_frame();
      drain(0, -1, -1, cyc, nd, errs);
      chk("after short: samples", nd, N);
      chk("after short: errors", errs, 0);
      chk("after short: I n=0", got_i[0], -256);

      fill_rand();
      send_frame();
      chk("overflow before stray blocks", int'(overflow), 0);
      drain(0, 50, -1, cyc, nd, errs);
      chk("overflow frame samples", nd, N);
      chk("overflow frame data intact", errs, 0);
      chk("overflow set", int'(overflow), 1);
      tick();
      tick();
      chk("overflow sticky", int'(overflow), 1);
      chk("busy after overflow frame", int'(busy), 0);

      fill_rand();
      send_frame();
      drain(0, -1, 100, cyc, nd, errs);
      chk("partial drain reached n=100", nd, 100);
      chk("partial drain errors", errs, 0);
      rst = 1'b1;
      #1;
      chk("async reset dout_valid", int'(dout_valid), 0);
      chk("async reset dout_i", int'(dout_i), 0);
      chk("async reset dout_q", int'(dout_q), 0);
      chk("async reset dout_index", int'(dout_index), 0);
      chk("async reset dout_last", int'(dout_last), 0);
      chk("async reset busy", int'(busy), 0);
      chk("async reset overflow", int'(overflow), 0);
      tick();
      rst = 1'b0;
      tick();
      fill_ramp();
      send_frame();
      drain(0, -1, -1, cyc, nd, errs);
      chk("after reset: samples", nd, N);
      chk("after reset: errors", errs, 0);
      chk("after reset: I n=0", got_i[0], -256);

      for (int f = 0; f < 3; f++) begin
         fill_rand();
         repeat ($urandom_range(0, 3)) tick();
         send_frame();
         drain(3, -1, -1, cyc, nd, errs);
         chk($sformatf("random frame %0d samples", f), nd, N);
         chk($sformatf("random frame %0d errors", f), errs, 0);
         chk($sformatf("random frame %0d idle after", f), int'(dout_valid) + int'(busy), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
